turn_controller: RTL and testbench

//  Upstream move-entry stage for the limited-marks tic-tac-toe core. Turns raw

---
 rtl/turn_controller.sv | 192 +++++++++++++++++++
 tb/tb_turn_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/turn_controller.sv
// Move-entry stage: turns player buttons into a 3x3 cursor, validates moves
// against the recorder grid, issues one-cycle mark commands and owns whosTurn.
module turn_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
  parameter logic        START_PLAYER   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_state,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_confirm,
  input  logic [1:0] g0,
  input  logic [1:0] g1,
  input  logic [1:0] g2,
  input  logic [1:0] g3,
  input  logic [1:0] g4,
  input  logic [1:0] g5,
  input  logic [1:0] g6,
  input  logic [1:0] g7,
  input  logic [1:0] g8,
  output logic [3:0] cursor,
  output logic [3:0] position,
  output logic [1:0] mark,
  output logic       whosTurn,
  output logic       reject,
  output logic       timeout
);

  localparam int unsigned TW     = (TIMEOUT_CYCLES == 32'd0) ? 1 : $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam bit          TO_EN  = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    COMMIT = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cursor_q, cursor_d;
  logic [3:0]    position_q, position_d;
  logic [1:0]    mark_q, mark_d;
  logic          whos_turn_q, whos_turn_d;
  logic          reject_q, reject_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    btn_q, btn_d;
  logic [4:0]    ev_s;
  logic [1:0]    cell_s;
  logic          move_s;
  logic          tick_s;

  // Bit order {right, left, down, up, confirm}; low index wins on simultaneous events.
  assign btn_d = {btn_right, btn_left, btn_down, btn_up, btn_confirm};
  assign ev_s  = btn_d & ~btn_q;

  // Occupancy of the highlighted cell.
  always_comb begin
    cell_s = 2'b00;
    case (cursor_q)
      4'd0:    cell_s = g0;
      4'd1:    cell_s = g1;
      4'd2:    cell_s = g2;
      4'd3:    cell_s = g3;
      4'd4:    cell_s = g4;
      4'd5:    cell_s = g5;
      4'd6:    cell_s = g6;
      4'd7:    cell_s = g7;
      4'd8:    cell_s = g8;
      default: cell_s = 2'b00;
    endcase
  end

  // Next-state, cursor, timer and output-pulse logic.
  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    position_d  = position_q;
    mark_d      = 2'b00;
    whos_turn_d = whos_turn_q;
    reject_d    = 1'b0;
    timeout_d   = 1'b0;
    timer_d     = timer_q;
    move_s      = 1'b0;
    tick_s      = 1'b0;

    if (!game_state) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SELECT;
          whos_turn_d = START_PLAYER;
          cursor_d    = 4'd4;
          timer_d     = '0;
        end
        SELECT: begin
          if (ev_s[0]) begin
            if (cell_s != 2'b00) begin
              reject_d = 1'b1;
              tick_s   = 1'b1;
            end else begin
              position_d = cursor_q;
              mark_d     = whos_turn_q ? 2'b10 : 2'b01;
              state_d    = COMMIT;
            end
          end else if (ev_s[1]) begin
            move_s   = 1'b1;
            cursor_d = (cursor_q < 4'd3) ? cursor_q + 4'd6 : cursor_q - 4'd3;
          end else if (ev_s[2]) begin
            move_s   = 1'b1;
            cursor_d = (cursor_q > 4'd5) ? cursor_q - 4'd6 : cursor_q + 4'd3;
          end else if (ev_s[3]) begin
            move_s   = 1'b1;
            cursor_d = ((cursor_q % 4'd3) == 4'd0) ? cursor_q + 4'd2 : cursor_q - 4'd1;
          end else if (ev_s[4]) begin
            move_s   = 1'b1;
            cursor_d = ((cursor_q % 4'd3) == 4'd2) ? cursor_q - 4'd2 : cursor_q + 4'd1;
          end else begin
            tick_s = 1'b1;
          end

          // A rejected confirm still counts as inactivity for the forfeit timer.
          if (move_s) begin
            timer_d = '0;
          end else if (tick_s) begin
            if (TO_EN && (timer_q == T_LAST)) begin
              timeout_d   = 1'b1;
              whos_turn_d = ~whos_turn_q;
              timer_d     = '0;
            end else if (timer_q != '1) begin
              timer_d = timer_q + TW'(1);
            end else begin
              timer_d = timer_q;
            end
          end else begin
            timer_d = timer_q;
          end
        end
        COMMIT: begin
          state_d = SETTLE;
        end
        SETTLE: begin
          state_d     = SELECT;
          whos_turn_d = ~whos_turn_q;
          timer_d     = '0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cursor_q    <= 4'd4;
      position_q  <= 4'd0;
      mark_q      <= 2'b00;
      whos_turn_q <= START_PLAYER;
      reject_q    <= 1'b0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
      btn_q       <= 5'b00000;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      position_q  <= position_d;
      mark_q      <= mark_d;
      whos_turn_q <= whos_turn_d;
      reject_q    <= reject_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
      btn_q       <= btn_d;
    end
  end

  assign cursor   = cursor_q;
  assign position = position_q;
  assign mark     = mark_q;
  assign whosTurn = whos_turn_q;
  assign reject   = reject_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed scenarios plus random
// button/grid traffic, all checked cycle by cycle against a behavioural model.
module tb_turn_controller;

  localparam int TO = 8;
  localparam logic [4:0] B_C = 5'b00001;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b10000;
  localparam int M_IDLE = 0, M_SEL = 1, M_COM = 2, M_SET = 3;

  logic clk = 1'b0;
  logic rst;
  logic game_state;
  logic btn_up, btn_down, btn_left, btn_right, btn_confirm;
  logic [1:0] grid [9];
  logic [3:0] cursor, position;
  logic [1:0] mark;
  logic whosTurn, reject, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_mode, m_cur, m_pos, m_whos, m_timer, m_mark, m_rej, m_to;
  logic [4:0] m_prev;

  turn_controller #(.TIMEOUT_CYCLES(TO), .START_PLAYER(1'b1)) dut (
    .clk(clk), .rst(rst), .game_state(game_state),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_confirm(btn_confirm),
    .g0(grid[0]), .g1(grid[1]), .g2(grid[2]), .g3(grid[3]), .g4(grid[4]),
    .g5(grid[5]), .g6(grid[6]), .g7(grid[7]), .g8(grid[8]),
    .cursor(cursor), .position(position), .mark(mark),
    .whosTurn(whosTurn), .reject(reject), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cur = 4; m_pos = 0; m_whos = 1; m_timer = 0;
    m_mark = 0; m_rej = 0; m_to = 0; m_prev = 5'b00000;
  endtask

  // One inactive SELECT cycle: forfeit after TO consecutive idle cycles.
  task automatic tick();
    m_timer++;
    if (m_timer == TO) begin
      m_to = 1; m_whos ^= 1; m_timer = 0;
    end
  endtask

  task automatic model_step(input logic [4:0] b, input logic gs);
    logic [4:0] ev;
    int sel, row, col;
    ev = b & ~m_prev;
    m_prev = b;
    m_mark = 0; m_rej = 0; m_to = 0;
    if (!gs) begin
      m_mode = M_IDLE; m_timer = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin m_mode = M_SEL; m_whos = 1; m_cur = 4; m_timer = 0; end
        M_SEL: begin
          sel = -1;
          for (int i = 0; i < 5; i++) if (ev[i] && sel < 0) sel = i;
          row = m_cur / 3; col = m_cur % 3;
          case (sel)
            0: begin
              if (grid[m_cur] != 2'b00) begin m_rej = 1; tick(); end
              else begin m_pos = m_cur; m_mark = m_whos ? 2 : 1; m_mode = M_COM; end
            end
            1: begin row = (row + 2) % 3; m_timer = 0; end
            2: begin row = (row + 1) % 3; m_timer = 0; end
            3: begin col = (col + 2) % 3; m_timer = 0; end
            4: begin col = (col + 1) % 3; m_timer = 0; end
            default: tick();
          endcase
          m_cur = row * 3 + col;
        end
        M_COM: m_mode = M_SET;
        default: begin m_mode = M_SEL; m_whos ^= 1; m_timer = 0; end
      endcase
    end
  endtask

  task automatic cycle(input logic [4:0] b, input logic gs);
    {btn_right, btn_left, btn_down, btn_up, btn_confirm} = b;
    game_state = gs;
    @(posedge clk);
    model_step(b, gs);
    #1;
    check("cursor", cursor, m_cur);
    check("position", position, m_pos);
    check("mark", mark, m_mark);
    check("whosTurn", whosTurn, m_whos);
    check("reject", reject, m_rej);
    check("timeout", timeout, m_to);
  endtask

  initial begin
    logic [4:0] b;
    logic gs;
    rst = 1'b0;
    game_state = 1'b0;
    {btn_right, btn_left, btn_down, btn_up, btn_confirm} = 5'b00000;
    for (int i = 0; i < 9; i++) grid[i] = 2'b00;
    model_reset();
    #12;
    check("rst_cursor", cursor, 4);
    check("rst_position", position, 0);
    check("rst_mark", mark, 0);
    check("rst_whos", whosTurn, 1);
    check("rst_reject", reject, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b1;

    // Cursor wrap
    cycle(5'b0, 1'b1);
    cycle(B_R, 1'b1); check("wrap_r1", cursor, 5);
    cycle(5'b0, 1'b1);
    cycle(B_R, 1'b1); check("wrap_r2", cursor, 3);
    cycle(5'b0, 1'b1);
    cycle(B_U, 1'b1); check("up_0", cursor, 0);
    cycle(5'b0, 1'b1);
    cycle(B_U, 1'b1); check("up_wrap6", cursor, 6);
    cycle(5'b0, 1'b1);
    cycle(B_R, 1'b1);
    cycle(5'b0, 1'b1);
    cycle(B_U, 1'b1); check("back_to_4", cursor, 4);
    cycle(5'b0, 1'b1);

    // Commit X at 4
    cycle(B_C, 1'b1);
    check("commit_mark", mark, 2'b10);
    check("commit_pos", position, 4);
    cycle(5'b0, 1'b1);
    check("settle_mark", mark, 0);
    check("settle_whos", whosTurn, 1);
    grid[4] = 2'b10;
    cycle(5'b0, 1'b1);
    check("toggled_whos", whosTurn, 0);

    // Confirm on occupied cell
    cycle(B_C, 1'b1);
    check("rej_pulse", reject, 1);
    check("rej_mark", mark, 0);
    check("rej_whos", whosTurn, 0);
    cycle(5'b0, 1'b1);
    check("rej_drop", reject, 0);

    // Confirm + left together, then held
    grid[4] = 2'b00;
    cycle(B_C | B_L, 1'b1);
    check("cl_mark", mark, 2'b01);
    check("cl_pos", position, 4);
    check("cl_cursor", cursor, 4);
    for (int i = 0; i < 4; i++) begin
      cycle(B_C | B_L, 1'b1);
      check("hold_cursor", cursor, 4);
      check("hold_mark", mark, 0);
    end
    grid[4] = 2'b01;
    cycle(5'b0, 1'b1);

    // Inactivity forfeit
    cycle(B_R, 1'b1);
    for (int i = 0; i < 7; i++) cycle(5'b0, 1'b1);
    check("to_early", timeout, 0);
    cycle(5'b0, 1'b1);
    check("to_pulse", timeout, 1);
    check("to_whos", whosTurn, 0);
    check("to_mark", mark, 0);
    cycle(5'b0, 1'b1);
    check("to_drop", timeout, 0);

    // Stop during SETTLE, then restart
    cycle(B_C, 1'b1);
    check("c5_pos", position, 5);
    cycle(5'b0, 1'b1);
    cycle(5'b0, 1'b0);
    check("stop_whos", whosTurn, 0);
    check("stop_mark", mark, 0);
    cycle(5'b0, 1'b1);
    check("restart_whos", whosTurn, 1);
    check("restart_cursor", cursor, 4);

    // Random traffic with a recorder-like grid
    for (int i = 0; i < 9; i++) grid[i] = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      b = 5'b0;
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) b[i] = 1'b1;
      gs = ($urandom_range(0, 149) != 0);
      cycle(b, gs);
      if (mark != 2'b00 && position < 9 && $urandom_range(0, 3) != 0) grid[position] = mark;
      if ($urandom_range(0, 199) == 0) for (int i = 0; i < 9; i++) grid[i] = 2'b00;
    end

    // Async reset while a mark is being issued
    for (int i = 0; i < 9; i++) grid[i] = 2'b00;
    cycle(5'b0, 1'b1);
    cycle(5'b0, 1'b1);
    cycle(5'b0, 1'b1);
    cycle(B_C, 1'b1);
    check("pre_rst_mark_valid", (mark != 2'b00), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_mark", mark, 0);
    check("async_whos", whosTurn, 1);
    check("async_cursor", cursor, 4);
    model_reset();
    rst = 1'b1;
    cycle(5'b0, 1'b1);
    cycle(B_D, 1'b1);
    check("post_rst_down", cursor, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
